// File: rtl/div3_serial.sv
// div3_serial: bit-serial long division by 3.
// Consumes one dividend bit per clock, MSB first, and produces the full
// quotient, the 2-bit remainder and a divisibility flag. Operands and results
// are exchanged over valid/ready handshakes. Only one operation is in flight
// at a time.
module div3_serial #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] quotient,
    output logic [1:0]        remainder,
    output logic              divisibility
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    // Working registers
    logic [DATA_W-1:0] r_shift;
    logic [DATA_W-1:0] r_wq;
    logic [1:0]        r_rem;
    logic [CNT_W-1:0]  r_cnt;

    // Result registers
    logic [DATA_W-1:0] r_quot;
    logic [1:0]        r_remo;
    logic              r_div;

    // Per-bit recurrence signals
    logic              w_b;
    logic [2:0]        w_t;
    logic              w_q;
    logic [1:0]        w_rem_next;
    logic [DATA_W-1:0] w_wq_next;
    logic              w_last;
    logic              w_accept;

    // One step of the mod-3 recurrence: t = 2*rem + b, q = (t >= 3), rem' = t - 3q
    always_comb begin
        w_b        = r_shift[DATA_W-1];
        w_t        = {r_rem, 1'b0} + {2'b00, w_b};
        w_q        = (w_t >= 3'd3);
        w_rem_next = 2'd0;
        case (w_t)
            3'd0:    w_rem_next = 2'd0;
            3'd1:    w_rem_next = 2'd1;
            3'd2:    w_rem_next = 2'd2;
            3'd3:    w_rem_next = 2'd0;
            3'd4:    w_rem_next = 2'd1;
            3'd5:    w_rem_next = 2'd2;
            default: w_rem_next = 2'd0;
        endcase
        w_wq_next  = {r_wq[DATA_W-2:0], w_q};
        w_last     = (r_cnt == CNT_ONE);
        w_accept   = in_valid && (r_state == S_IDLE);
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded handshake outputs
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                if (w_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Working datapath: load on acceptance, advance one bit per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift <= '0;
            r_wq    <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (w_accept) begin
            r_shift <= data;
            r_wq    <= '0;
            r_rem   <= '0;
            r_cnt   <= CNT_LOAD;
        end else if (r_state == S_RUN) begin
            r_shift <= {r_shift[DATA_W-2:0], 1'b0};
            r_wq    <= w_wq_next;
            r_rem   <= w_rem_next;
            r_cnt   <= r_cnt - CNT_ONE;
        end
    end

    // Result registers: written only on the last RUN cycle, held otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quot <= '0;
            r_remo <= '0;
            r_div  <= 1'b1;
        end else if ((r_state == S_RUN) && w_last) begin
            r_quot <= w_wq_next;
            r_remo <= w_rem_next;
            r_div  <= (w_rem_next == 2'd0);
        end
    end

    assign quotient     = r_quot;
    assign remainder    = r_remo;
    assign divisibility = r_div;

endmodule

// File: tb/tb_div3_serial.sv
// Self-checking bench for div3_serial at DATA_W=8 and DATA_W=5.
// Expected results come from plain integer x/3 and x%3.
module tb_div3_serial;

    logic clk;
    logic rst_n;

    // DATA_W = 8 instance
    logic       in_valid8, in_ready8, out_valid8, out_ready8, div8;
    logic [7:0] data8, quot8;
    logic [1:0] rem8;

    // DATA_W = 5 instance
    logic       in_valid5, in_ready5, out_valid5, out_ready5, div5;
    logic [4:0] data5, quot5;
    logic [1:0] rem5;

    int checks;
    int errors;

    div3_serial #(.DATA_W(8)) u_dut8 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid8),
        .in_ready     (in_ready8),
        .data         (data8),
        .out_valid    (out_valid8),
        .out_ready    (out_ready8),
        .quotient     (quot8),
        .remainder    (rem8),
        .divisibility (div8)
    );

    div3_serial #(.DATA_W(5)) u_dut5 (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid5),
        .in_ready     (in_ready5),
        .data         (data5),
        .out_valid    (out_valid5),
        .out_ready    (out_ready5),
        .quotient     (quot5),
        .remainder    (rem5),
        .divisibility (div5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One DATA_W=8 operation; stall randomises out_ready while the result waits
    task automatic run8(input int x, input bit stall);
        int n;
        int eq, er;
        eq = x / 3;
        er = x % 3;
        check("idle_rdy8", {31'd0, in_ready8}, 1);
        data8      = x[7:0];
        in_valid8  = 1'b1;
        out_ready8 = stall ? 1'b0 : 1'b1;
        tick();
        in_valid8 = 1'b0;
        data8     = 8'($urandom);
        n = 0;
        while (!out_valid8 && n < 20) begin
            if (n == 3) check("run_rdy8", {31'd0, in_ready8}, 0);
            tick();
            n++;
        end
        check("lat8", n, 8);
        check("quot8", {24'd0, quot8}, eq);
        check("rem8",  {30'd0, rem8}, er);
        check("div8",  {31'd0, div8}, (er == 0) ? 1 : 0);
        n = 0;
        while (out_valid8 && n < 40) begin
            if (stall) out_ready8 = ($urandom_range(0, 3) == 0);
            if (n >= 20) out_ready8 = 1'b1;
            tick();
            n++;
            if (out_valid8) begin
                check("hold_q8", {24'd0, quot8}, eq);
                check("hold_rdy8", {31'd0, in_ready8}, 0);
            end
        end
        if (!stall) check("drain8", n, 1);
        check("done_ov8", {31'd0, out_valid8}, 0);
        check("done_rdy8", {31'd0, in_ready8}, 1);
        check("keep_q8", {24'd0, quot8}, eq);
        check("keep_r8", {30'd0, rem8}, er);
    endtask

    // One DATA_W=5 operation with random output stalls
    task automatic run5(input int x);
        int n;
        int eq, er;
        eq = x / 3;
        er = x % 3;
        check("idle_rdy5", {31'd0, in_ready5}, 1);
        data5      = x[4:0];
        in_valid5  = 1'b1;
        out_ready5 = 1'($urandom_range(0, 1));
        tick();
        in_valid5 = 1'b0;
        data5     = 5'($urandom);
        n = 0;
        while (!out_valid5 && n < 20) begin
            tick();
            n++;
        end
        check("lat5", n, 5);
        check("quot5", {27'd0, quot5}, eq);
        check("rem5",  {30'd0, rem5}, er);
        check("div5",  {31'd0, div5}, (er == 0) ? 1 : 0);
        n = 0;
        while (out_valid5 && n < 40) begin
            out_ready5 = (n >= 20) ? 1'b1 : 1'($urandom_range(0, 1));
            tick();
            n++;
            if (out_valid5) check("hold_q5", {27'd0, quot5}, eq);
        end
        check("done_rdy5", {31'd0, in_ready5}, 1);
    endtask

    task automatic check_reset8(input string tag);
        check({tag, "_rdy"}, {31'd0, in_ready8}, 1);
        check({tag, "_ov"},  {31'd0, out_valid8}, 0);
        check({tag, "_q"},   {24'd0, quot8}, 0);
        check({tag, "_r"},   {30'd0, rem8}, 0);
        check({tag, "_d"},   {31'd0, div8}, 1);
    endtask

    initial begin
        int n;
        checks = 0;
        errors = 0;
        rst_n = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; data8 = '0;
        in_valid5 = 1'b0; out_ready5 = 1'b0; data5 = '0;
        #12;
        check_reset8("rst");
        check("rst_rdy5", {31'd0, in_ready5}, 1);
        check("rst_d5",   {31'd0, div5}, 1);
        tick();
        rst_n = 1'b1;
        tick();

        // Directed values
        run8(123, 1'b0);
        run8(32, 1'b0);
        run8(255, 1'b0);
        run8(0, 1'b0);
        run8(1, 1'b0);
        run8(2, 1'b0);
        run8(3, 1'b0);

        // Back-pressure with an illegal in_valid pulse train carrying 7
        data8 = 8'd32; in_valid8 = 1'b1; out_ready8 = 1'b0;
        tick();
        in_valid8 = 1'b0;
        n = 0;
        while (!out_valid8 && n < 20) begin
            tick();
            n++;
        end
        check("bp_lat", n, 8);
        for (int i = 0; i < 5; i++) begin
            in_valid8 = 1'b1;
            data8     = 8'd7;
            tick();
            check("bp_q",   {24'd0, quot8}, 10);
            check("bp_r",   {30'd0, rem8}, 2);
            check("bp_ov",  {31'd0, out_valid8}, 1);
            check("bp_rdy", {31'd0, in_ready8}, 0);
        end
        in_valid8  = 1'b0;
        out_ready8 = 1'b1;
        tick();
        check("bp_idle_rdy", {31'd0, in_ready8}, 1);
        check("bp_idle_ov",  {31'd0, out_valid8}, 0);
        check("bp_keep_q",   {24'd0, quot8}, 10);

        // Reset during RUN
        data8 = 8'd200; in_valid8 = 1'b1; out_ready8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        tick(); tick(); tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_reset8("mid_rst");
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_ov", {31'd0, out_valid8}, 0);
        run8(9, 1'b0);

        // Exhaustive sweeps with random stalls
        for (int x = 0; x < 256; x++) run8(x, 1'b1);
        for (int x = 0; x < 32; x++) run5(x);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
